// File: rtl/snake_pkg.sv
//==============================================================================
// snake_pkg: grid defaults, coordinate width and food-spawn FSM encoding
// Rev 1.0
//==============================================================================
`default_nettype none

package snake_pkg;

  localparam int c_GRID_W  = 32;
  localparam int c_GRID_H  = 24;
  localparam int c_COORD_W = 5;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_SAMPLE    = 3'd1;
  localparam logic [2:0] c_ST_WAIT      = 3'd2;
  localparam logic [2:0] c_ST_SCAN      = 3'd3;
  localparam logic [2:0] c_ST_SCAN_WAIT = 3'd4;
  localparam logic [2:0] c_ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = c_ST_IDLE,
    ST_SAMPLE    = c_ST_SAMPLE,
    ST_WAIT      = c_ST_WAIT,
    ST_SCAN      = c_ST_SCAN,
    ST_SCAN_WAIT = c_ST_SCAN_WAIT,
    ST_DONE      = c_ST_DONE
  } spawn_state_e;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_scan_cnt.sv
//==============================================================================
// grid_scan_cnt: x-fastest raster counter over the grid with last-cell flag
// Rev 1.0
//==============================================================================
`default_nettype none

module grid_scan_cnt
  import snake_pkg::*;
#(
  parameter int GRID_W = c_GRID_W,
  parameter int GRID_H = c_GRID_H
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_clr,
  input  logic                 I_adv,
  output logic [c_COORD_W-1:0] O_x,
  output logic [c_COORD_W-1:0] O_y,
  output logic                 O_last
);

  localparam logic [c_COORD_W-1:0] c_X_MAX = c_COORD_W'(GRID_W - 1);
  localparam logic [c_COORD_W-1:0] c_Y_MAX = c_COORD_W'(GRID_H - 1);

  logic [c_COORD_W-1:0] r_x;
  logic [c_COORD_W-1:0] r_y;
  logic                 w_last;

  assign w_last = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

  // Advancing past the last cell holds position; the FSM never asks for it.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (I_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (I_adv && !w_last) begin
      if (r_x == c_X_MAX) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign O_x    = r_x;
  assign O_y    = r_y;
  assign O_last = w_last;

endmodule

`default_nettype wire

// File: rtl/food_spawn_ctrl.sv
//==============================================================================
// food_spawn_ctrl: random food placement with retry and raster-scan fallback
// Rev 1.0
//==============================================================================
`default_nettype none

module food_spawn_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W    = c_GRID_W,
  parameter int GRID_H    = c_GRID_H,
  parameter int MAX_TRIES = 16,
  parameter int INIT_X    = 16,
  parameter int INIT_Y    = 12
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_rand_num,
  input  logic       I_spawn_req,
  output logic       O_busy,
  output logic       O_occ_vld,
  output logic [4:0] O_occ_x,
  output logic [4:0] O_occ_y,
  input  logic       I_occ_hit,
  output logic [4:0] O_food_x,
  output logic [4:0] O_food_y,
  output logic       O_food_vld,
  output logic       O_fail
);

  spawn_state_e r_state, w_state_nxt;
  logic [5:0]   r_tries, w_tries_nxt, w_tries_inc;
  logic         w_tries_done;
  logic [4:0]   w_cx, w_cy;
  logic         w_in_range;
  logic [4:0]   r_cand_x, r_cand_y;
  logic [4:0]   r_food_x, r_food_y;
  logic         r_fail, w_fail_nxt;
  logic         w_load_cand, w_load_scan;
  logic         w_scan_clr, w_scan_adv, w_scan_last;
  logic [4:0]   w_scan_x, w_scan_y;

  assign w_cx         = I_rand_num[4:0];
  assign w_cy         = I_rand_num[9:5];
  assign w_in_range   = (int'(w_cx) < GRID_W) && (int'(w_cy) < GRID_H);
  assign w_tries_inc  = sat_inc6(r_tries);
  assign w_tries_done = (w_tries_inc >= 6'(MAX_TRIES));

  grid_scan_cnt #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_scan (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_clr   (w_scan_clr),
    .I_adv   (w_scan_adv),
    .O_x     (w_scan_x),
    .O_y     (w_scan_y),
    .O_last  (w_scan_last)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state  <= ST_IDLE;
      r_tries  <= '0;
      r_cand_x <= '0;
      r_cand_y <= '0;
      r_food_x <= 5'(INIT_X);
      r_food_y <= 5'(INIT_Y);
      r_fail   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tries <= w_tries_nxt;
      r_fail  <= w_fail_nxt;
      if (r_state == ST_SAMPLE) begin
        r_cand_x <= w_cx;
        r_cand_y <= w_cy;
      end
      if (w_load_cand) begin
        r_food_x <= r_cand_x;
        r_food_y <= r_cand_y;
      end else if (w_load_scan) begin
        r_food_x <= w_scan_x;
        r_food_y <= w_scan_y;
      end
    end
  end

  // Queries are decoded straight from state so the strobe lands in the SAMPLE/SCAN cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_fail_nxt  = 1'b0;
    w_load_cand = 1'b0;
    w_load_scan = 1'b0;
    w_scan_clr  = 1'b0;
    w_scan_adv  = 1'b0;
    O_occ_vld   = 1'b0;
    O_occ_x     = '0;
    O_occ_y     = '0;
    O_food_vld  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_scan_clr = 1'b1;
        if (I_spawn_req) begin
          w_state_nxt = ST_SAMPLE;
          w_tries_nxt = '0;
        end
      end
      ST_SAMPLE: begin
        if (w_in_range) begin
          O_occ_vld   = 1'b1;
          O_occ_x     = w_cx;
          O_occ_y     = w_cy;
          w_state_nxt = ST_WAIT;
        end else begin
          w_tries_nxt = w_tries_inc;
          w_state_nxt = w_tries_done ? ST_SCAN : ST_SAMPLE;
        end
      end
      ST_WAIT: begin
        if (!I_occ_hit) begin
          w_load_cand = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_tries_nxt = w_tries_inc;
          w_state_nxt = w_tries_done ? ST_SCAN : ST_SAMPLE;
        end
      end
      ST_SCAN: begin
        O_occ_vld   = 1'b1;
        O_occ_x     = w_scan_x;
        O_occ_y     = w_scan_y;
        w_state_nxt = ST_SCAN_WAIT;
      end
      ST_SCAN_WAIT: begin
        if (!I_occ_hit) begin
          w_load_scan = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (!w_scan_last) begin
          w_scan_adv  = 1'b1;
          w_state_nxt = ST_SCAN;
        end else begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        O_food_vld  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign O_busy   = (r_state != ST_IDLE);
  assign O_food_x = r_food_x;
  assign O_food_y = r_food_y;
  assign O_fail   = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_food_spawn_ctrl.sv
//==============================================================================
// tb_food_spawn_ctrl: scoreboard bench with a queue-based reference model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_food_spawn_ctrl;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int MT = 16;
  localparam int IX = 16;
  localparam int IY = 12;

  logic       I_clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic [9:0] I_rand_num = '0;
  logic       I_spawn_req = 1'b0;
  logic       I_occ_hit = 1'b0;
  logic       O_busy, O_occ_vld, O_food_vld, O_fail;
  logic [4:0] O_occ_x, O_occ_y, O_food_x, O_food_y;

  food_spawn_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT), .INIT_X(IX), .INIT_Y(IY)
  ) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_rand_num (I_rand_num),
    .I_spawn_req(I_spawn_req),
    .O_busy     (O_busy),
    .O_occ_vld  (O_occ_vld),
    .O_occ_x    (O_occ_x),
    .O_occ_y    (O_occ_y),
    .I_occ_hit  (I_occ_hit),
    .O_food_x   (O_food_x),
    .O_food_y   (O_food_y),
    .O_food_vld (O_food_vld),
    .O_fail     (O_fail)
  );

  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  typedef struct { int x; int y; int c; } qry_t;
  typedef struct { bit fail; int x; int y; int c; } res_t;

  qry_t       exp_q[$];
  res_t       res_q[$];
  logic [9:0] word_q[$];
  logic [9:0] wq[$];
  bit         occ[GW][GH];
  int         food_x = IX;
  int         food_y = IY;
  int         total = 0;
  int         bad = 0;
  int         pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the word stream sample by sample, then fall back to first free raster cell.
  function automatic void predict(input int k);
    int t = 0;
    int tries = 0;
    int cx, cy;
    logic [9:0] v;
    while (tries < MT) begin
      v  = wq[t];
      cx = int'(v[4:0]);
      cy = int'(v[9:5]);
      if (cx >= GW || cy >= GH) begin
        t++;
        tries++;
      end else begin
        exp_q.push_back('{cx, cy, k + t});
        if (!occ[cx][cy]) begin
          res_q.push_back('{1'b0, cx, cy, k + t + 2});
          food_x = cx;
          food_y = cy;
          return;
        end
        t += 2;
        tries++;
      end
    end
    for (int i = 0; i < GW * GH; i++) begin
      exp_q.push_back('{i % GW, i / GW, k + t + 2 * i});
      if (!occ[i % GW][i / GW]) begin
        res_q.push_back('{1'b0, i % GW, i / GW, k + t + 2 * i + 2});
        food_x = i % GW;
        food_y = i / GW;
        return;
      end
    end
    res_q.push_back('{1'b1, food_x, food_y, k + t + 2 * GW * GH});
  endfunction

  task automatic tick();
    @(posedge I_clk);
    #1;
    I_spawn_req = 1'b0;
    if (word_q.size() > 0) I_rand_num = word_q.pop_front();
    else I_rand_num = 10'($urandom);
  endtask

  task automatic issue();
    while (wq.size() < 40) wq.push_back(10'($urandom));
    I_spawn_req = 1'b1;
    predict(cyc + 1);
    word_q = wq;
  endtask

  task automatic wait_done();
    int n = 0;
    tick();
    while (res_q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (res_q.size() > 0) begin
      check("timeout", 1, 0);
      res_q.delete();
    end
    repeat (3) tick();
    check("queries_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fill_occ(input int pct);
    foreach (occ[i, j]) occ[i][j] = ($urandom_range(0, 99) < pct);
  endtask

  function automatic logic [9:0] rand_word();
    logic [4:0] x;
    logic [4:0] y;
    x = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 99) < 30) y = 5'($urandom_range(GH, 31));
    else y = 5'($urandom_range(0, GH - 1));
    return {y, x};
  endfunction

  // Occupancy responder: answers each query one cycle later and checks it against the model.
  initial begin
    bit prev_vld = 1'b0;
    bit cur_vld;
    int qx, qy;
    qry_t e;
    forever begin
      @(negedge I_clk);
      cur_vld = I_rst_n && O_occ_vld;
      qx = int'(O_occ_x);
      qy = int'(O_occ_y);
      if (cur_vld) begin
        check("occ_back_to_back", prev_vld, 0);
        if (exp_q.size() == 0) check("occ_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("occ_x", qx, e.x);
          check("occ_y", qy, e.y);
          check("occ_cycle", cyc, e.c);
        end
      end
      prev_vld = cur_vld;
      @(posedge I_clk);
      #1;
      I_occ_hit = (cur_vld && qx < GW && qy < GH) ? occ[qx][qy] : 1'b0;
    end
  end

  // Result monitor
  initial begin
    res_t r;
    forever begin
      @(negedge I_clk);
      if (I_rst_n && (O_food_vld || O_fail)) begin
        pulse_cnt++;
        if (res_q.size() == 0) check("pulse_unexpected", 1, 0);
        else begin
          r = res_q.pop_front();
          check("fail_flag", O_fail, r.fail);
          check("food_vld", O_food_vld, !r.fail);
          check("food_x", O_food_x, r.x);
          check("food_y", O_food_y, r.y);
          check("pulse_cycle", cyc, r.c);
          check("busy_at_pulse", O_busy, !r.fail);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int dens[5] = '{0, 40, 80, 97, 100};
    foreach (occ[i, j]) occ[i][j] = 1'b0;
    repeat (3) tick();
    check("rst_food_x", O_food_x, IX);
    check("rst_food_y", O_food_y, IY);
    check("rst_busy", O_busy, 0);
    check("rst_occ_vld", O_occ_vld, 0);
    check("rst_occ_xy", {O_occ_x, O_occ_y}, 0);
    check("rst_food_vld", O_food_vld, 0);
    check("rst_fail", O_fail, 0);
    I_rst_n = 1'b1;
    repeat (2) tick();

    // direct hit at (3,5)
    wq.delete(); wq.push_back(10'b00101_00011);
    issue(); wait_done();

    // two off-grid samples, then (7,9)
    wq.delete(); wq.push_back({5'd30, 5'd0}); wq.push_back({5'd30, 5'd0}); wq.push_back({5'd9, 5'd7});
    issue(); wait_done();

    // occupied (3,5) then free (4,6)
    occ[3][5] = 1'b1;
    wq.delete(); wq.push_back({5'd5, 5'd3}); wq.push_back(10'h3ff); wq.push_back({5'd6, 5'd4});
    issue(); wait_done();

    // all random tries land on occupied (0,0)/(1,0); scan finds (2,0)
    foreach (occ[i, j]) occ[i][j] = 1'b0;
    occ[0][0] = 1'b1; occ[1][0] = 1'b1;
    wq.delete();
    for (int i = 0; i < MT; i++) begin
      wq.push_back({5'd0, 5'(i % 2)});
      wq.push_back(10'h3ff);
    end
    issue(); wait_done();
    check("scan_food_x", O_food_x, 2);

    // full grid: fail pulse, food unchanged
    foreach (occ[i, j]) occ[i][j] = 1'b1;
    wq.delete();
    issue(); wait_done();

    // requests while busy are dropped
    foreach (occ[i, j]) occ[i][j] = 1'b0;
    occ[3][5] = 1'b1;
    wq.delete(); wq.push_back({5'd5, 5'd3}); wq.push_back(10'h3ff); wq.push_back({5'd6, 5'd4});
    pc = pulse_cnt;
    issue();
    for (int i = 0; i < 3; i++) begin
      tick();
      I_spawn_req = 1'b1;
    end
    wait_done();
    repeat (5) tick();
    check("busy_req_pulses", pulse_cnt - pc, 1);

    // reset asserted during WAIT
    foreach (occ[i, j]) occ[i][j] = 1'b0;
    wq.delete(); wq.push_back({5'd8, 5'd2});
    pc = pulse_cnt;
    issue();
    tick();
    tick();
    I_rst_n = 1'b0;
    #2;
    check("rst_mid_busy", O_busy, 0);
    res_q.delete();
    exp_q.delete();
    food_x = IX;
    food_y = IY;
    tick();
    check("rst_mid_food_x", O_food_x, IX);
    check("rst_mid_food_y", O_food_y, IY);
    I_rst_n = 1'b1;
    repeat (6) tick();
    check("rst_mid_no_pulse", pulse_cnt - pc, 0);

    // randomized runs
    for (int n = 0; n < 25; n++) begin
      fill_occ(dens[$urandom_range(0, 4)]);
      wq.delete();
      for (int i = 0; i < 40; i++) wq.push_back(rand_word());
      issue();
      wait_done();
    end
    check("final_food_x", O_food_x, food_x);
    check("final_food_y", O_food_y, food_y);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
